// File: rtl/pc_gen_axi.sv
// -----------------------------------------------------------------------------
// pc_gen_axi
//   Program-counter generator for the AXI-Lite instruction fetch path. Holds
//   the fetch PC, issues one fetch request per PC over a valid/ready handshake,
//   and applies branch and flush redirects. A redirect that arrives while a
//   request is waiting for ready is parked in a pending register and applied
//   when the handshake completes.
//
// Parameters
//   ADDR_W     PC / address width (>= 2)
//   RESET_VEC  PC value after reset
//   INC        sequential PC increment
//   STALL_W    stall vector width; only bit 0 (PC stage) is used here
//
// Ports
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   stall           in   pipeline stall vector; stall[0] freezes the PC stage
//   flush           in   exception/eret flush, redirect to new_pc
//   new_pc          in   flush target
//   branch_flag_i   in   branch taken (from ID)
//   branch_target_i in   branch target
//   req_valid       out  fetch request valid
//   req_ready       in   bridge accepts the request
//   pc              out  fetch address; stable while req_valid=1, req_ready=0
//   ce              out  fetch enable, low for the first cycle after reset
//   drop_o          out  the instruction for this handshake must be discarded
//   adel_o          out  misaligned fetch address
//
// Build option
//   PC_ALIGN_CHECK_EN  when defined, a misaligned PC blocks the request and
//                      raises adel_o until a flush loads a new PC. When
//                      undefined, adel_o is tied low and any PC is issued.
// -----------------------------------------------------------------------------
module pc_gen_axi #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC       = 4,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               drop_o,
  output logic               adel_o
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  typedef enum logic [1:0] {
    ST_OFF,   // first cycle after reset, fetch disabled
    ST_RUN,   // normal fetch, nothing pending
    ST_PEND   // redirect parked behind an outstanding request
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic                req_valid_d;
  logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic                pend_flush_q, pend_flush_d;

  logic br_take;   // branch is ignored while the PC stage is stalled
  logic hs;
  logic waiting;   // request outstanding, bridge not ready
  logic pending;

  // Only the PC-stage bit of the stall vector matters to this block.
  logic stall_unused;
  assign stall_unused = ^stall[STALL_W-1:1];

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  logic adel_keep;
  logic misaligned;
  assign adel_o = adel_q;
`else
  assign adel_o = 1'b0;
`endif

  assign br_take = branch_flag_i & ~stall[0];
  assign hs      = req_valid & req_ready;
  assign waiting = req_valid & ~req_ready;
  assign pending = (state_q == ST_PEND);
  assign ce      = (state_q != ST_OFF);

  // A flush taken at the handshake, or one parked earlier, means the fetch
  // going out now is on the squashed path. Branches never drop: the in-flight
  // fetch is the delay slot.
  assign drop_o  = hs & (flush | (pending & pend_flush_q));

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    req_valid_d  = req_valid;
    pend_tgt_d   = pend_tgt_q;
    pend_flush_d = pend_flush_q;
`ifdef PC_ALIGN_CHECK_EN
    adel_d       = adel_q;
    adel_keep    = 1'b0;
    misaligned   = 1'b0;
`endif

    unique case (state_q)
      ST_OFF: state_d = ST_RUN;

      ST_RUN, ST_PEND: begin
        if (waiting) begin
          // PC and req_valid are frozen; a redirect is parked instead. A flush
          // always overwrites; a branch never overwrites a parked flush.
          if (flush) begin
            pend_tgt_d   = new_pc;
            pend_flush_d = 1'b1;
            state_d      = ST_PEND;
          end else if (br_take && !(pending && pend_flush_q)) begin
            pend_tgt_d   = branch_target_i;
            pend_flush_d = 1'b0;
            state_d      = ST_PEND;
          end
        end else begin
          // Handshake or idle. ST_PEND implies req_valid=1, so reaching here
          // in ST_PEND always means the handshake is happening.
          if (flush)               pc_d = new_pc;
          else if (hs && pending)  pc_d = pend_tgt_q;
          else if (br_take)        pc_d = branch_target_i;
          else if (hs)             pc_d = pc + INC_V;

          state_d      = ST_RUN;
          pend_flush_d = 1'b0;

`ifdef PC_ALIGN_CHECK_EN
          // A raised alignment error survives everything but a flush.
          misaligned  = (pc_d[1:0] != 2'b00);
          adel_keep   = adel_q & ~flush;
          adel_d      = adel_keep | (~stall[0] & misaligned);
          req_valid_d = ~stall[0] & ~misaligned & ~adel_keep;
`else
          req_valid_d = ~stall[0];
`endif
        end
      end

      default: state_d = ST_OFF;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      pc           <= RESET_VEC;
      req_valid    <= 1'b0;
      pend_tgt_q   <= '0;
      pend_flush_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      adel_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      req_valid    <= req_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_flush_q <= pend_flush_d;
`ifdef PC_ALIGN_CHECK_EN
      adel_q       <= adel_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_gen_axi.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_axi
//   Self-checking bench for pc_gen_axi. A directed sequence walks through the
//   reset, sequential fetch, held-redirect, flush/drop, stall and wrap cases,
//   then a randomized phase drives all inputs from $urandom. Every cycle the
//   outputs are compared with a behavioural fetch model kept in the bench.
// -----------------------------------------------------------------------------
module tb_pc_gen_axi;

  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;
  localparam int INC     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               drop_o;
  logic               adel_o;

  pc_gen_axi #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (32'h0000_0000),
    .INC       (INC),
    .STALL_W   (STALL_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .pc              (pc),
    .ce              (ce),
    .drop_o          (drop_o),
    .adel_o          (adel_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: the fetch front end described as "what address is being
  // requested, is it offered, and which redirect is waiting for the handshake".
  // ---------------------------------------------------------------------------
  bit          m_started;   // fetch enabled (first clock after reset done)
  bit          m_offer;     // a request is being offered
  int unsigned m_addr;      // address being requested / to request next
  bit          m_have_redir;
  bit          m_redir_is_flush;
  int unsigned m_redir_addr;
  bit          m_align_err;

  int unsigned hs_log[$];

  task automatic model_reset();
    m_started = 0; m_offer = 0; m_addr = 0;
    m_have_redir = 0; m_redir_is_flush = 0; m_redir_addr = 0;
    m_align_err = 0;
  endtask

  function automatic bit model_drop();
    return m_offer && req_ready && (flush || (m_have_redir && m_redir_is_flush));
  endfunction

  // Advance the model by one clock using the inputs presented in this cycle.
  task automatic model_step();
    bit          br;
    bit          want;
    bit          bad;
    int unsigned nxt;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_started) begin
      m_started = 1;
      return;
    end
    br = branch_flag_i && !stall[0];
    if (m_offer && !req_ready) begin
      if (flush) begin
        m_have_redir = 1; m_redir_is_flush = 1; m_redir_addr = new_pc;
      end else if (br && !(m_have_redir && m_redir_is_flush)) begin
        m_have_redir = 1; m_redir_is_flush = 0; m_redir_addr = branch_target_i;
      end
      return;
    end
    // Handshake (m_offer) or idle (no offer).
    if (flush)                     nxt = new_pc;
    else if (m_offer && m_have_redir) nxt = m_redir_addr;
    else if (br)                   nxt = branch_target_i;
    else if (m_offer)              nxt = m_addr + INC;   // 32-bit wrap
    else                           nxt = m_addr;
    m_addr       = nxt;
    m_have_redir = 0;
    m_redir_is_flush = 0;
    want = !stall[0];
`ifdef PC_ALIGN_CHECK_EN
    bad = (nxt % 4) != 0;
    if (flush) m_align_err = 0;
    if (m_align_err) begin
      m_offer = 0;
    end else if (want && bad) begin
      m_align_err = 1;
      m_offer     = 0;
    end else begin
      m_offer = want;
    end
`else
    bad     = 0;
    m_offer = want || bad;
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
      end
  endtask

  // Mid-cycle: compare all outputs with the model for the current inputs.
  task automatic half();
    @(negedge clk);
    check("ce",        32'(ce),        32'(m_started));
    check("req_valid", 32'(req_valid), 32'(m_offer));
    check("pc",        pc,             m_addr);
    check("drop_o",    32'(drop_o),    32'(model_drop()));
    check("adel_o",    32'(adel_o),    32'(m_align_err));
    if (!rst && req_valid && req_ready) hs_log.push_back(pc);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    half();
    edge_step();
  endtask

  task automatic idle_inputs();
    stall = '0; flush = 0; new_pc = '0;
    branch_flag_i = 0; branch_target_i = '0; req_ready = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    edge_step();
    edge_step();

    // Reset values
    half();
    check("rst_pc",    pc,               32'h0);
    check("rst_ce",    32'(ce),          32'h0);
    check("rst_valid", 32'(req_valid),   32'h0);
    edge_step();

    // 1: sequential fetch with ready held high
    rst = 0; req_ready = 1;
    half(); check("t1_ce0", 32'(ce), 32'h0); edge_step();
    half(); check("t1_ce1", 32'(ce), 32'h1); edge_step();
    hs_log.delete();
    repeat (4) tick();
    check("t1_hs_count", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      check($sformatf("t1_hs%0d", i), hs_log[i], 32'(i * 4));

    // 2: branch while ready is low is held until the handshake
    req_ready = 0; branch_flag_i = 1; branch_target_i = 32'h100;
    half(); check("t2_hold0", pc, 32'h10); edge_step();
    branch_flag_i = 0;
    half(); check("t2_hold1", pc, 32'h10); edge_step();
    half(); check("t2_hold2", pc, 32'h10); edge_step();
    req_ready = 1;
    half(); check("t2_hs_drop", 32'(drop_o), 32'h0); edge_step();
    req_ready = 0;
    half(); check("t2_pc", pc, 32'h100); edge_step();

    // 4: stalled, idle, branch ignored; flush still accepted
    stall = 6'b000001; req_ready = 1;
    tick();                                    // handshake, valid drops
    req_ready = 0; branch_flag_i = 1; branch_target_i = 32'h500;
    tick();
    half();
    check("t4_valid", 32'(req_valid), 32'h0);
    check("t4_pc",    pc,             32'h104);
    edge_step();
    branch_flag_i = 0; flush = 1; new_pc = 32'h380;
    tick();
    flush = 0;
    half(); check("t4_flush_pc", pc, 32'h380); edge_step();

    // 3: branch then flush parked at pc=0x20; flush wins and drops
    flush = 1; new_pc = 32'h20;
    tick();
    flush = 0; stall = '0;
    tick();
    branch_flag_i = 1; branch_target_i = 32'h200;
    half(); check("t3_pc20", pc, 32'h20); edge_step();
    branch_flag_i = 0; flush = 1; new_pc = 32'h380;
    tick();
    flush = 0;
    tick();
    req_ready = 1;
    half(); check("t3_drop", 32'(drop_o), 32'h1); edge_step();
    req_ready = 0;
    half();
    check("t3_pc",    pc,          32'h380);
    check("t3_drop1", 32'(drop_o), 32'h0);
    edge_step();

    // 5: address wrap
    req_ready = 1; stall = 6'b000001;
    tick();
    req_ready = 0; flush = 1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 0; stall = '0;
    tick();
    req_ready = 1;
    half(); check("t5_pc_top", pc, 32'hFFFF_FFFC); edge_step();
    half(); check("t5_wrap", pc, 32'h0); edge_step();

    // 6: misaligned branch target
    stall = 6'b000001;
    tick();
    stall = '0; req_ready = 0; branch_flag_i = 1; branch_target_i = 32'h102;
    tick();
    branch_flag_i = 0;
`ifdef PC_ALIGN_CHECK_EN
    half();
    check("t6_valid", 32'(req_valid), 32'h0);
    check("t6_adel",  32'(adel_o),    32'h1);
    edge_step();
    flush = 1; new_pc = 32'h380;
    tick();
    flush = 0;
    half();
    check("t6_adel_clr", 32'(adel_o),    32'h0);
    check("t6_resume",   32'(req_valid), 32'h1);
    check("t6_pc",       pc,             32'h380);
    edge_step();
`else
    half();
    check("t6_valid", 32'(req_valid), 32'h1);
    check("t6_adel",  32'(adel_o),    32'h0);
    check("t6_pc",    pc,             32'h102);
    edge_step();
`endif

    // Randomized phase against the model
    for (int c = 0; c < 1500; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      stall           = STALL_W'($urandom);
      stall[0]        = ($urandom_range(0, 3) == 0);
      flush           = ($urandom_range(0, 9) == 0);
      new_pc          = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & ~32'h3);
      branch_flag_i   = ($urandom_range(0, 2) == 0);
      branch_target_i = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & ~32'h3);
      req_ready       = ($urandom_range(0, 4) < 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
